// File: rtl/timer_array.sv
// timer_array: bank of N_CH independent down-counting timers behind a
// word-addressed register bus. Each channel has CTRL/PRESET/COUNT/STATUS
// registers, an optional prescaler and a sticky pending flag that drives IRQ.
// Bus: no handshake. A write commits on the rising edge where WE=1; Dout is
// a pure combinational function of Addr and current register contents.
module timer_array #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:2]       Addr,
    input  logic              WE,
    input  logic [31:0]       Din,
    output logic [31:0]       Dout,
    output logic [N_CH-1:0]   IRQ,
    output logic              IRQ_any,
    output logic [2*N_CH-1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CNT  = 2'd1,
        S_INT  = 2'd2
    } state_t;

    localparam logic [1:0] SEL_CTRL   = 2'd0;
    localparam logic [1:0] SEL_PRESET = 2'd1;
    localparam logic [1:0] SEL_COUNT  = 2'd2;
    localparam logic [1:0] SEL_STATUS = 2'd3;

    logic [7:0]       r_ctrl   [N_CH];
    logic [CNT_W-1:0] r_preset [N_CH];
    logic [CNT_W-1:0] r_count  [N_CH];
    logic [3:0]       r_psc    [N_CH];
    logic             r_pend   [N_CH];
    state_t           r_state  [N_CH];

    logic [2:0]      w_ch;
    logic [1:0]      w_sel;
    logic [N_CH-1:0] w_wr_ctrl;
    logic [N_CH-1:0] w_wr_preset;
    logic [N_CH-1:0] w_clr_pend;
    logic            w_unused;

    assign w_ch     = Addr[6:4];
    assign w_sel    = Addr[3:2];
    assign w_unused = &{1'b0, Addr[31:7]};

    // Decode per-channel write strobes; channels >= N_CH never match
    always_comb begin
        w_wr_ctrl   = '0;
        w_wr_preset = '0;
        w_clr_pend  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (WE && (w_ch == 3'(i))) begin
                w_wr_ctrl[i]   = (w_sel == SEL_CTRL);
                w_wr_preset[i] = (w_sel == SEL_PRESET);
                w_clr_pend[i]  = (w_sel == SEL_STATUS) && Din[0];
            end
        end
    end

    // Per-channel FSM and registers; later assignments in this block take
    // priority, so pending-set beats STATUS clear and a software CTRL write
    // beats the one-shot En clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                r_ctrl[i]   <= '0;
                r_preset[i] <= '0;
                r_count[i]  <= '0;
                r_psc[i]    <= '0;
                r_pend[i]   <= 1'b0;
                r_state[i]  <= S_IDLE;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (w_clr_pend[i]) begin
                    r_pend[i] <= 1'b0;
                end
                case (r_state[i])
                    S_IDLE: begin
                        if (r_ctrl[i][0]) begin
                            r_count[i] <= r_preset[i];
                            r_psc[i]   <= '0;
                            r_state[i] <= S_CNT;
                        end
                    end
                    S_CNT: begin
                        if (!r_ctrl[i][0]) begin
                            r_state[i] <= S_IDLE;
                        end else if (r_psc[i] == r_ctrl[i][7:4]) begin
                            r_psc[i] <= '0;
                            if (r_count[i] != '0) begin
                                r_count[i] <= r_count[i] - CNT_W'(1);
                            end else begin
                                r_state[i] <= S_INT;
                                r_pend[i]  <= 1'b1;
                            end
                        end else begin
                            r_psc[i] <= r_psc[i] + 4'd1;
                        end
                    end
                    S_INT: begin
                        // Mode 01 reloads; 00 and 1x behave as one-shot
                        if (r_ctrl[i][2:1] == 2'b01) begin
                            r_count[i] <= r_preset[i];
                            r_psc[i]   <= '0;
                            r_state[i] <= S_CNT;
                        end else begin
                            r_ctrl[i][0] <= 1'b0;
                            r_state[i]   <= S_IDLE;
                        end
                    end
                    default: r_state[i] <= S_IDLE;
                endcase
                if (w_wr_ctrl[i]) begin
                    r_ctrl[i] <= Din[7:0];
                end
                if (w_wr_preset[i]) begin
                    r_preset[i] <= Din[CNT_W-1:0];
                end
            end
        end
    end

    // Read mux, interrupt outputs and debug state view
    always_comb begin
        Dout        = '0;
        IRQ         = '0;
        o_dbg_state = '0;
        for (int i = 0; i < N_CH; i++) begin
            IRQ[i]               = r_pend[i] & r_ctrl[i][3];
            o_dbg_state[2*i +: 2] = r_state[i];
            if (w_ch == 3'(i)) begin
                case (w_sel)
                    SEL_CTRL:   Dout = {24'd0, r_ctrl[i]};
                    SEL_PRESET: Dout = 32'(r_preset[i]);
                    SEL_COUNT:  Dout = 32'(r_count[i]);
                    default:    Dout = {31'd0, r_pend[i]};
                endcase
            end
        end
        IRQ_any = |IRQ;
    end

endmodule

// File: tb/tb_timer_array.sv
// Directed bench for timer_array (N_CH=2, CNT_W=32). Stimulus is a linear
// list of bus writes and cycle steps; each expected value is hand-derived
// from the edge count since the enabling CTRL write.
module tb_timer_array;

    logic        clk;
    logic        reset;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic [1:0]  IRQ;
    logic        IRQ_any;
    logic [3:0]  dbg;

    int n_checks = 0;
    int n_errors = 0;

    timer_array #(.N_CH(2), .CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .Addr       (Addr),
        .WE         (WE),
        .Din        (Din),
        .Dout       (Dout),
        .IRQ        (IRQ),
        .IRQ_any    (IRQ_any),
        .o_dbg_state(dbg)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:2] adr(input logic [2:0] ch, input logic [1:0] sel);
        return {25'd0, ch, sel};
    endfunction

    // bus write committed on the next rising edge; returns 1ns after it
    task automatic wr(input logic [2:0] ch, input logic [1:0] sel, input logic [31:0] d);
        Addr = adr(ch, sel);
        Din  = d;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE   = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic [2:0] ch, input logic [1:0] sel,
                          input logic [31:0] exp);
        Addr = adr(ch, sel);
        #1;
        chk(tag, Dout, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        WE    = 1'b0;
        Addr  = '0;
        Din   = '0;
        step(3);
        reset = 1'b0;

        // reset state
        chk_rd("rst_ctrl0", 3'd0, 2'd0, 32'h0);
        chk_rd("rst_count0", 3'd0, 2'd2, 32'h0);
        chk("rst_irq", 32'(IRQ), 32'h0);
        chk("rst_irq_any", 32'(IRQ_any), 32'h0);
        chk("rst_state", 32'(dbg), 32'h0);

        // one-shot, PRESET=5, IM=1
        wr(3'd0, 2'd1, 32'd5);
        wr(3'd0, 2'd0, 32'h9);
        chk("os_state_e0", 32'(dbg[1:0]), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            chk_rd($sformatf("os_count_e%0d", k), 3'd0, 2'd2, 32'(6 - k));
        end
        chk("os_irq_e6", 32'(IRQ), 32'h0);
        step(1);
        chk("os_irq_e7", 32'(IRQ), 32'h1);
        chk("os_irq_any_e7", 32'(IRQ_any), 32'h1);
        chk("os_state_e7", 32'(dbg[1:0]), 32'd2);
        chk_rd("os_status_e7", 3'd0, 2'd3, 32'h1);
        step(1);
        chk_rd("os_ctrl_after", 3'd0, 2'd0, 32'h8);
        chk("os_state_e8", 32'(dbg[1:0]), 32'd0);
        wr(3'd0, 2'd3, 32'h1);
        chk("os_irq_clr", 32'(IRQ), 32'h0);
        chk("os_irq_any_clr", 32'(IRQ_any), 32'h0);

        // auto-reload ch1, PRESET=3
        wr(3'd1, 2'd1, 32'd3);
        wr(3'd1, 2'd0, 32'hB);
        step(4);
        chk_rd("ar_count_e4", 3'd1, 2'd2, 32'd0);
        chk("ar_irq_e4", 32'(IRQ), 32'h0);
        step(1);
        chk("ar_irq_e5", 32'(IRQ), 32'h2);
        chk("ar_state_e5", 32'(dbg[3:2]), 32'd2);
        step(1);
        chk_rd("ar_reload_e6", 3'd1, 2'd2, 32'd3);
        chk("ar_state_e6", 32'(dbg[3:2]), 32'd1);
        wr(3'd1, 2'd3, 32'h1);
        chk("ar_irq_clr_e7", 32'(IRQ), 32'h0);
        chk_rd("ar_count_e7", 3'd1, 2'd2, 32'd2);
        step(2);
        chk_rd("ar_count_e9", 3'd1, 2'd2, 32'd0);
        chk_rd("ar_pend_e9", 3'd1, 2'd3, 32'd0);
        wr(3'd1, 2'd3, 32'h1);
        chk_rd("ar_set_wins_e10", 3'd1, 2'd3, 32'd1);
        chk("ar_state_e10", 32'(dbg[3:2]), 32'd2);
        chk_rd("ar_ch0_untouched", 3'd0, 2'd0, 32'h8);
        wr(3'd1, 2'd0, 32'h0);
        step(1);
        chk("ar_state_off", 32'(dbg[3:2]), 32'd0);
        chk_rd("ar_count_off", 3'd1, 2'd2, 32'd3);
        wr(3'd1, 2'd3, 32'h1);
        chk("ar_irq_off", 32'(IRQ), 32'h0);

        // prescaler PSC=3, PRESET=2
        wr(3'd0, 2'd1, 32'd2);
        wr(3'd0, 2'd0, 32'h39);
        step(1);
        chk_rd("psc_count_e1", 3'd0, 2'd2, 32'd2);
        step(3);
        chk_rd("psc_count_e4", 3'd0, 2'd2, 32'd2);
        step(1);
        chk_rd("psc_count_e5", 3'd0, 2'd2, 32'd1);
        step(4);
        chk_rd("psc_count_e9", 3'd0, 2'd2, 32'd0);
        step(3);
        chk("psc_irq_e12", 32'(IRQ), 32'h0);
        step(1);
        chk("psc_irq_e13", 32'(IRQ), 32'h1);
        step(1);
        chk_rd("psc_ctrl_after", 3'd0, 2'd0, 32'h38);
        wr(3'd0, 2'd3, 32'h1);

        // mid-count disable, COUNT write ignored, re-enable, reset mid-count
        wr(3'd0, 2'd1, 32'd6);
        wr(3'd0, 2'd0, 32'h9);
        step(2);
        chk_rd("mid_count_e2", 3'd0, 2'd2, 32'd5);
        wr(3'd0, 2'd0, 32'h0);
        chk_rd("mid_count_e3", 3'd0, 2'd2, 32'd4);
        step(1);
        chk("mid_state_idle", 32'(dbg[1:0]), 32'd0);
        wr(3'd0, 2'd2, 32'h1234);
        chk_rd("mid_count_wr_ignored", 3'd0, 2'd2, 32'd4);
        step(2);
        chk_rd("mid_count_hold", 3'd0, 2'd2, 32'd4);
        chk("mid_irq", 32'(IRQ), 32'h0);
        wr(3'd0, 2'd0, 32'h9);
        step(1);
        chk_rd("mid_reload", 3'd0, 2'd2, 32'd6);
        step(2);
        chk_rd("mid_count_f3", 3'd0, 2'd2, 32'd4);
        reset = 1'b1;
        wr(3'd1, 2'd1, 32'h77);
        reset = 1'b0;
        chk_rd("rst2_ctrl0", 3'd0, 2'd0, 32'h0);
        chk_rd("rst2_preset0", 3'd0, 2'd1, 32'h0);
        chk_rd("rst2_count0", 3'd0, 2'd2, 32'h0);
        chk_rd("rst2_preset1", 3'd1, 2'd1, 32'h0);
        chk("rst2_irq", 32'(IRQ), 32'h0);
        chk("rst2_state", 32'(dbg), 32'h0);

        // IM=0 expiry with PRESET=0, then late IM, out-of-range channel
        wr(3'd1, 2'd1, 32'd0);
        wr(3'd1, 2'd0, 32'h1);
        step(1);
        chk("im0_state_e1", 32'(dbg[3:2]), 32'd1);
        step(1);
        chk_rd("im0_status_e2", 3'd1, 2'd3, 32'h1);
        chk("im0_irq_e2", 32'(IRQ), 32'h0);
        chk("im0_irq_any_e2", 32'(IRQ_any), 32'h0);
        step(1);
        chk_rd("im0_ctrl_e3", 3'd1, 2'd0, 32'h0);
        wr(3'd1, 2'd0, 32'h8);
        chk("im1_irq", 32'(IRQ), 32'h2);
        chk("im1_irq_any", 32'(IRQ_any), 32'h1);
        wr(3'd2, 2'd1, 32'h55);
        chk_rd("oor_read", 3'd2, 2'd1, 32'h0);
        wr(3'd2, 2'd0, 32'h9);
        chk_rd("oor_ctrl0", 3'd0, 2'd0, 32'h0);
        chk_rd("oor_preset0", 3'd0, 2'd1, 32'h0);
        chk("oor_irq", 32'(IRQ), 32'h2);
        wr(3'd1, 2'd3, 32'h1);
        wr(3'd1, 2'd0, 32'h0);

        // software CTRL write on the one-shot INT edge keeps En
        wr(3'd0, 2'd1, 32'd0);
        wr(3'd0, 2'd0, 32'h1);
        step(2);
        chk("sw_state_int", 32'(dbg[1:0]), 32'd2);
        wr(3'd0, 2'd0, 32'h1);
        chk_rd("sw_ctrl_kept", 3'd0, 2'd0, 32'h1);
        chk("sw_state_idle", 32'(dbg[1:0]), 32'd0);
        step(1);
        chk("sw_state_cnt", 32'(dbg[1:0]), 32'd1);
        wr(3'd0, 2'd0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
